// File: rtl/cell_update_seq.sv
// Sequences the cell-state multiply-add over all hidden units. Each unit takes five steps:
// fetch, wait, f*c multiply, one datapath cycle, then write-back of the saturated c_new.
module cell_update_seq #(
  parameter int          NUM_UNITS        = 32,
  parameter int          ADDR_W           = 5,
  parameter logic [7:0]  OUT_ZERO_SIGMOID = 8'd0,
  parameter logic [7:0]  ZERO_STATE       = 8'd128,
  parameter logic [4:0]  CTRL_MAQ         = 5'd7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        f_data,
  input  logic [7:0]        i_data,
  input  logic [7:0]        g_data,
  input  logic [7:0]        c_data,
  output logic [4:0]        comb_ctrl,
  output logic [16:0]       temp_regA,
  output logic [7:0]        temp_regB,
  output logic [7:0]        temp_regC,
  input  logic [7:0]        B_sat_MAQ,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_MAQ   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_UNIT = ADDR_W'(NUM_UNITS - 1);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic [7:0]        f_reg, i_reg, g_reg, c_reg;

  // Buffer data is only guaranteed in the cycle after rd_en, so it is captured in WAIT.
  logic signed [8:0]  f_diff;
  logic signed [8:0]  c_diff;
  logic signed [17:0] prod;

  assign f_diff = $signed({1'b0, f_reg}) - $signed({1'b0, OUT_ZERO_SIGMOID});
  assign c_diff = $signed({1'b0, c_reg}) - $signed({1'b0, ZERO_STATE});
  assign prod   = f_diff * c_diff;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      f_reg     <= '0;
      i_reg     <= '0;
      g_reg     <= '0;
      c_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      comb_ctrl <= '0;
      temp_regA <= '0;
      temp_regB <= '0;
      temp_regC <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      rd_en     <= 1'b0;
      done      <= 1'b0;
      comb_ctrl <= '0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
          end
        end
        S_FETCH: state_reg <= S_WAIT;
        S_WAIT: begin
          f_reg     <= f_data;
          i_reg     <= i_data;
          g_reg     <= g_data;
          c_reg     <= c_data;
          state_reg <= S_MUL;
        end
        S_MUL: begin
          temp_regA <= prod[16:0];
          temp_regB <= i_reg;
          temp_regC <= g_reg;
          // Registered so the opcode is presented during the MAQ cycle itself.
          comb_ctrl <= CTRL_MAQ;
          state_reg <= S_MAQ;
        end
        S_MAQ: begin
          wr_data   <= B_sat_MAQ;
          wr_addr   <= cnt_reg;
          wr_en     <= 1'b1;
          state_reg <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (cnt_reg == LAST_UNIT) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              cnt_reg   <= cnt_reg + ADDR_W'(1);
              rd_en     <= 1'b1;
              rd_addr   <= cnt_reg + ADDR_W'(1);
              state_reg <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_update_seq.sv
// Directed bench for cell_update_seq: buffer and datapath stand-ins, a write scoreboard
// fed by the stimulus, and a negedge monitor that pops and compares on every accepted write.
module tb_cell_update_seq;

  localparam int N = 32;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [4:0] rd_addr, wr_addr, comb_ctrl;
  logic [7:0] f_data = 8'd0, i_data = 8'd0, g_data = 8'd0, c_data = 8'd0;
  logic [16:0] temp_regA;
  logic [7:0] temp_regB, temp_regC, B_sat_MAQ, wr_data;
  logic       wr_ready = 1'b1;

  cell_update_seq dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .f_data(f_data), .i_data(i_data), .g_data(g_data), .c_data(c_data),
    .comb_ctrl(comb_ctrl), .temp_regA(temp_regA), .temp_regB(temp_regB),
    .temp_regC(temp_regC), .B_sat_MAQ(B_sat_MAQ),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Gate/state buffer stand-in: data present only in the cycle after rd_en.
  logic [7:0] f_mem [N], i_mem [N], g_mem [N], c_mem [N];
  always @(posedge clk) begin
    if (rd_en) begin
      f_data <= f_mem[rd_addr];
      i_data <= i_mem[rd_addr];
      g_data <= g_mem[rd_addr];
      c_data <= c_mem[rd_addr];
    end else begin
      f_data <= 8'd0;
      i_data <= 8'd0;
      g_data <= 8'd0;
      c_data <= 8'd0;
    end
  end

  function automatic int sat8(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // Quantization datapath stand-in: c_new = sat((A>>8) + ((i*(g-128))>>8) + 128).
  int dp_a, dp_ig;
  always_comb begin
    dp_a      = int'($signed(temp_regA));
    dp_ig     = int'(temp_regB) * (int'(temp_regC) - 128);
    B_sat_MAQ = 8'd0;
    if (comb_ctrl == 5'd7) B_sat_MAQ = 8'(sat8((dp_a >>> 8) + (dp_ig >>> 8) + 128));
  end

  // Write-side backpressure: hold wr_ready low bp_len cycles on unit bp_addr.
  int bp_addr = -1, bp_len = 0, bp_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (wr_en && int'(wr_addr) == bp_addr && bp_cnt < bp_len) begin
      wr_ready = 1'b0;
      bp_cnt++;
    end else begin
      wr_ready = 1'b1;
    end
  end

  typedef struct {
    int addr;
    int data;
    int a;
    int b;
    int c;
  } exp_t;
  exp_t sb[$];

  int ctrl_cnt = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  logic       prev_stall = 1'b0;
  logic [4:0] prev_addr;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (rstn) begin
      if (comb_ctrl == 5'd7) ctrl_cnt++;
      else if (comb_ctrl != 5'd0) chk("comb_ctrl_value", int'(comb_ctrl), 0);
      if (done) done_cnt++;
      if (rd_en) rd_cnt++;
      if (prev_stall) begin
        chk("stall_wr_en", int'(wr_en), 1);
        chk("stall_wr_addr", int'(wr_addr), int'(prev_addr));
        chk("stall_wr_data", int'(wr_data), int'(prev_data));
        chk("stall_no_rd_en", int'(rd_en), 0);
      end
      if (wr_en && wr_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", int'(wr_addr), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("wr_addr[%0d]", e.addr), int'(wr_addr), e.addr);
          chk($sformatf("wr_data[%0d]", e.addr), int'(wr_data), e.data);
          chk($sformatf("temp_regA[%0d]", e.addr), int'($signed(temp_regA)), e.a);
          chk($sformatf("temp_regB[%0d]", e.addr), int'(temp_regB), e.b);
          chk($sformatf("temp_regC[%0d]", e.addr), int'(temp_regC), e.c);
          $display("write addr=%0d data=%0d A=%0d", wr_addr, wr_data, $signed(temp_regA));
        end
      end
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load_unit(input int u, input int f, input int c, input int i, input int g);
    f_mem[u] = 8'(f);
    c_mem[u] = 8'(c);
    i_mem[u] = 8'(i);
    g_mem[u] = 8'(g);
  endtask

  task automatic load_random(input int first);
    for (int u = first; u < N; u++)
      load_unit(u, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
  endtask

  task automatic push_all();
    for (int u = 0; u < N; u++) begin
      exp_t e;
      e.addr = u;
      e.a    = int'(f_mem[u]) * (int'(c_mem[u]) - 128);
      e.b    = int'(i_mem[u]);
      e.c    = int'(g_mem[u]);
      e.data = sat8((e.a >>> 8) + ((e.b * (e.c - 128)) >>> 8) + 128);
      sb.push_back(e);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_comb_ctrl"}, int'(comb_ctrl), 0);
    chk({tag, "_temp_regA"}, int'(temp_regA), 0);
    chk({tag, "_temp_regB"}, int'(temp_regB), 0);
    chk({tag, "_temp_regC"}, int'(temp_regC), 0);
  endtask

  task automatic do_pass(input string tag, input int exp_cycles, input bit extra_start);
    int cyc;
    int ctrl0;
    int first_rd;
    ctrl0    = ctrl_cnt;
    cyc      = 0;
    first_rd = -1;
    @(negedge clk);
    start = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (rd_en && first_rd < 0) first_rd = cyc;
      if (extra_start && cyc == 20) start = 1'b1;
      if (extra_start && cyc == 21) start = 1'b0;
      if (done || cyc > 1000) break;
    end
    chk({tag, "_first_rd_latency"}, first_rd, 1);
    chk({tag, "_done_latency"}, cyc, exp_cycles);
    chk({tag, "_maq_cycles"}, ctrl_cnt - ctrl0, N);
    chk({tag, "_scoreboard_left"}, sb.size(), 0);
    // A start coinciding with done must not begin a new pass.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_done"}, int'(busy), 0);
    @(negedge clk);
    chk({tag, "_no_rd_after_done"}, int'(rd_en), 0);
    $display("pass %s done after %0d cycles", tag, cyc);
  endtask

  initial begin
    int wait_cyc;
    int done0;
    int rd0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vectors on units 0..2, random on the rest.
    load_unit(0, 128, 200, 0, 128);
    load_unit(1, 255, 255, 255, 255);
    load_unit(2, 255, 0, 255, 0);
    load_random(3);
    sb.push_back('{addr: 0, data: 164, a: 9216, b: 0, c: 128});
    sb.push_back('{addr: 1, data: 255, a: 32385, b: 255, c: 255});
    sb.push_back('{addr: 2, data: 0, a: -32640, b: 255, c: 0});
    for (int u = 3; u < N; u++) begin
      exp_t e;
      e.addr = u;
      e.a    = int'(f_mem[u]) * (int'(c_mem[u]) - 128);
      e.b    = int'(i_mem[u]);
      e.c    = int'(g_mem[u]);
      e.data = sat8((e.a >>> 8) + ((e.b * (e.c - 128)) >>> 8) + 128);
      sb.push_back(e);
    end
    do_pass("directed", 5 * N + 1, 1'b0);

    // Backpressure on unit 5.
    load_random(0);
    push_all();
    bp_cnt = 0; bp_len = 3; bp_addr = 5;
    do_pass("backpressure", 5 * N + 1 + 3, 1'b0);
    bp_addr = -1;

    // Reset while unit 10 waits in WRITE.
    load_random(0);
    push_all();
    bp_cnt = 0; bp_len = 1000; bp_addr = 10;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!(wr_en && wr_addr == 5'd10) && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("reach_write_unit10", int'(wr_en && wr_addr == 5'd10), 1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_outputs_zero("midpass_reset");
    sb.delete();
    bp_addr = -1;
    done0 = done_cnt;
    rd0   = rd_cnt;
    rstn  = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", done_cnt - done0, 0);
    chk("no_rd_after_reset", rd_cnt - rd0, 0);
    chk("idle_after_reset", int'(busy), 0);

    // Fresh pass restarts at address 0; a start while busy is ignored.
    load_random(0);
    push_all();
    do_pass("restart", 5 * N + 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_update_seq.md
Name: cell_update_seq

Overview:
- Sequencer for the combinational cell-state quantized multiply-add block (comb_ctrl code B_MAQ = 5'd7).
- For each hidden unit j in 0..NUM_UNITS-1 it performs four steps:
  - reads f_j, i_j, g_j and c_prev_j;
  - forms the f*c product operand;
  - drives the datapath with comb_ctrl = B_MAQ for one cycle;
  - writes the saturated c_new_j back to the state buffer.
- Sits between the gate/state buffers and the quantization datapath, and is started once per timestep by the LSTM top controller.

Parameters:
- NUM_UNITS, 32, number of hidden units processed per start.
- ADDR_W, 5, buffer address width; NUM_UNITS <= 2**ADDR_W.
- OUT_ZERO_SIGMOID, 8'd0, zero point subtracted from f.
- ZERO_STATE, 8'd128, zero point subtracted from c_prev.
- CTRL_MAQ, 5'd7, comb_ctrl code issued during the compute cycle.

Ports:
- clk  in  1  clock, rising-edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; begins a pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write of the pass.
- rd_en  out  1  read strobe to gate and state buffers.
- rd_addr  out  ADDR_W  read address (unit index).
- f_data  in  8  forget gate, valid the cycle after rd_en.
- i_data  in  8  input gate, valid the cycle after rd_en.
- g_data  in  8  candidate (tanh), valid the cycle after rd_en.
- c_data  in  8  c_prev, valid the cycle after rd_en.
- comb_ctrl  out  5  datapath opcode.
- temp_regA  out  17  signed (f-OUT_ZERO_SIGMOID)*(c-ZERO_STATE).
- temp_regB  out  8  registered i.
- temp_regC  out  8  registered g.
- B_sat_MAQ  in  8  saturated result from the datapath.
- wr_en  out  1  state buffer write request.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8  c_new.
- wr_ready  in  1  state buffer accepts the write this cycle.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - state goes to IDLE;
  - busy, done, rd_en and wr_en are 0;
  - comb_ctrl = 0, rd_addr = 0, wr_addr = 0, wr_data = 0;
  - temp_regA, temp_regB and temp_regC are 0;
  - the unit counter is 0.
  - Reset mid-pass abandons the pass: no further reads or writes, and no done pulse.
- All outputs are registered.
- States: IDLE, FETCH, WAIT, MUL, MAQ, WRITE, DONE.
- IDLE: start=1 moves to FETCH with counter=0 and busy=1. start while busy is ignored.
- FETCH: rd_en=1 and rd_addr=counter for exactly one cycle; then WAIT.
- WAIT: buffer data arrives; next state MUL.
- MUL:
  - temp_regA <= sign-extended 9-bit ({1'b0,f}-{1'b0,OUT_ZERO_SIGMOID}) times sign-extended 9-bit ({1'b0,c}-{1'b0,ZERO_STATE}), truncated to 17 bits signed. The range fits: -32640..32385.
  - temp_regB <= i_data and temp_regC <= g_data.
  - Next state MAQ.
- MAQ:
  - comb_ctrl = CTRL_MAQ for exactly this cycle (0 in every other state).
  - wr_data <= B_sat_MAQ, sampled at the end of the cycle.
  - wr_addr <= counter.
  - Next state WRITE.
- WRITE:
  - wr_en=1, holding wr_addr and wr_data stable, until wr_ready=1.
  - On the accept cycle:
    - if counter == NUM_UNITS-1, go to DONE;
    - otherwise counter+1 and go to FETCH.
  - temp_regA/B/C hold their values through WRITE.
- DONE: done=1 for one cycle, busy goes to 0, then IDLE.
- Throughput: 5 cycles per unit with wr_ready tied high. First rd_en is 1 cycle after start; done is 5*NUM_UNITS+1 cycles after start.
- Counter never wraps within a pass. NUM_UNITS=1 is legal: a single unit, then done.
- start in the same cycle as done is ignored. Start is accepted only in IDLE.

Test Plan:
- Single unit (datapath default params): f=128, c=200, i=0, g=128 -> temp_regA=9216; wr_data=164 at address 0; done pulses.
- Positive saturation: f=255, c=255, i=255, g=255 -> temp_regA=32385; wr_data=255.
- Negative saturation: f=255, c=0, i=255, g=0 -> temp_regA=-32640 (17'h18080); wr_data=0.
- Full pass, NUM_UNITS=32, wr_ready=1, random data:
  - 32 writes at addresses 0..31 matching a reference model;
  - done exactly 161 cycles after start;
  - comb_ctrl=7 asserted exactly 32 single cycles.
- Backpressure: wr_ready low for 3 cycles on unit 5 -> wr_en, wr_addr and wr_data stable; no new rd_en; pass completes 3 cycles later.
- rstn low while in WRITE of unit 10 -> all outputs 0 next cycle, no done pulse. A new start then restarts from address 0. A start pulse while busy has no effect.
